// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared forwarding-select codes and scoreboard state encoding for
//          the hazard/forwarding unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    SB_IDLE = 2'b00,
    SB_BUSY = 2'b01,
    SB_DONE = 2'b10
  } sb_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_scoreboard.sv
// ============================================================================
// Module : mdu_scoreboard
// Brief  : Tracks one outstanding multi-cycle MDU op; raises the writeback
//          strobe in its final cycle and flags D-stage conflicts while busy.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] write_reg_d,
  input  logic              reg_write_d,
  output logic              busy,
  output logic              raw_hit,
  output logic              waw_hit,
  output logic              done,
  output logic [REG_AW-1:0] done_dst
);

  localparam logic [3:0] c_CNT_INIT = 4'(MDU_LAT - 1);

  if (MDU_LAT < 2 || MDU_LAT > 15) begin : g_lat_check
    $error("mdu_scoreboard: MDU_LAT must be within 2..15");
  end

  sb_state_t         r_state, w_state_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [REG_AW-1:0] r_dst, w_dst_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SB_IDLE;
      r_cnt   <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_dst   <= w_dst_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dst_next   = r_dst;
    case (r_state)
      SB_BUSY: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd2) w_state_next = SB_DONE;
      end
      SB_DONE: begin
        w_state_next = SB_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = SB_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    // A new issue wins over retirement, so a DONE cycle can hand off directly.
    if (issue) begin
      w_dst_next   = issue_dst;
      w_cnt_next   = c_CNT_INIT;
      w_state_next = (c_CNT_INIT > 4'd1) ? SB_BUSY : SB_DONE;
    end
  end

  assign busy     = (r_state == SB_BUSY);
  assign done     = (r_state == SB_DONE);
  assign done_dst = done ? r_dst : '0;
  assign raw_hit  = busy && (((rs_d != '0) && (rs_d == r_dst)) ||
                             ((rt_d != '0) && (rt_d == r_dst)));
  assign waw_hit  = busy && reg_write_d && (write_reg_d == r_dst);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module : hazard_scoreboard_unit
// Brief  : 5-stage MIPS hazard/forwarding unit with a one-op MDU scoreboard.
//          Define HAZARD_PERF_EN to add saturating stall-cause counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs_D,
  input  logic [REG_AW-1:0] Rt_D,
  input  logic [REG_AW-1:0] Write_Reg_D,
  input  logic              Reg_Write_D,
  input  logic              Branch_D,
  input  logic              Mdu_D,
  input  logic [REG_AW-1:0] Rs_E,
  input  logic [REG_AW-1:0] Rt_E,
  input  logic [REG_AW-1:0] Write_Reg_E,
  input  logic              Reg_Write_E,
  input  logic              MemtoReg_E,
  input  logic              Mdu_E,
  input  logic [REG_AW-1:0] Write_Reg_M,
  input  logic              Reg_Write_M,
  input  logic              MemtoReg_M,
  input  logic [REG_AW-1:0] Write_Reg_W,
  input  logic              Reg_Write_W,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Flush_E,
  output logic [1:0]        Forward_AE,
  output logic [1:0]        Forward_BE,
  output logic              Forward_AD,
  output logic              Forward_BD,
  output logic              Mdu_Done,
  output logic [REG_AW-1:0] Mdu_Dst
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  Lw_Stall_Cnt,
  output logic [CNT_W-1:0]  Br_Stall_Cnt,
  output logic [CNT_W-1:0]  Mdu_Stall_Cnt
`endif
);

  logic w_m_fwd_ok, w_w_fwd_ok;
  logic w_lw_stall, w_br_stall, w_mdu_stall, w_stall;
  logic w_mdu_busy, w_mdu_raw, w_mdu_waw, w_mdu_str;

  assign w_m_fwd_ok = Reg_Write_M && (Write_Reg_M != '0);
  assign w_w_fwd_ok = Reg_Write_W && (Write_Reg_W != '0);

  assign Forward_AE = (w_m_fwd_ok && (Write_Reg_M == Rs_E)) ? FWD_MEM :
                      (w_w_fwd_ok && (Write_Reg_W == Rs_E)) ? FWD_WB  : FWD_RF;
  assign Forward_BE = (w_m_fwd_ok && (Write_Reg_M == Rt_E)) ? FWD_MEM :
                      (w_w_fwd_ok && (Write_Reg_W == Rt_E)) ? FWD_WB  : FWD_RF;
  assign Forward_AD = w_m_fwd_ok && (Write_Reg_M == Rs_D);
  assign Forward_BD = w_m_fwd_ok && (Write_Reg_M == Rt_D);

  assign w_lw_stall = MemtoReg_E && (Write_Reg_E != '0) &&
                      ((Rs_D == Write_Reg_E) || (Rt_D == Write_Reg_E));
  // Branch compares in D, so an ALU result still in E or a load still in M must be waited on.
  assign w_br_stall = Branch_D &&
                      ((Reg_Write_E && (Write_Reg_E != '0) &&
                        ((Rs_D == Write_Reg_E) || (Rt_D == Write_Reg_E))) ||
                       (MemtoReg_M && (Write_Reg_M != '0) &&
                        ((Rs_D == Write_Reg_M) || (Rt_D == Write_Reg_M))));

  mdu_scoreboard #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT)
  ) u_mdu_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (Mdu_E && (Write_Reg_E != '0)),
    .issue_dst   (Write_Reg_E),
    .rs_d        (Rs_D),
    .rt_d        (Rt_D),
    .write_reg_d (Write_Reg_D),
    .reg_write_d (Reg_Write_D),
    .busy        (w_mdu_busy),
    .raw_hit     (w_mdu_raw),
    .waw_hit     (w_mdu_waw),
    .done        (Mdu_Done),
    .done_dst    (Mdu_Dst)
  );

  assign w_mdu_str   = Mdu_D && w_mdu_busy;
  assign w_mdu_stall = w_mdu_raw || w_mdu_waw || w_mdu_str;
  assign w_stall     = w_lw_stall || w_br_stall || w_mdu_stall;

  assign Stall_F = w_stall;
  assign Stall_D = w_stall;
  assign Flush_E = w_stall;

`ifdef HAZARD_PERF_EN
  logic [2:0]       w_cause;
  logic [CNT_W-1:0] r_perf_cnt [3];

  assign w_cause = {w_mdu_stall, w_br_stall, w_lw_stall};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_perf_cnt[gi] <= '0;
      end else if (w_cause[gi] && (r_perf_cnt[gi] != '1)) begin
        r_perf_cnt[gi] <= r_perf_cnt[gi] + 1'b1;
      end
    end
  end

  assign Lw_Stall_Cnt  = r_perf_cnt[0];
  assign Br_Stall_Cnt  = r_perf_cnt[1];
  assign Mdu_Stall_Cnt = r_perf_cnt[2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
// ============================================================================
// Module : tb_hazard_scoreboard_unit
// Brief  : Directed self-checking bench for hazard_scoreboard_unit (MDU_LAT=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs_D, Rt_D, Write_Reg_D, Rs_E, Rt_E, Write_Reg_E, Write_Reg_M, Write_Reg_W;
  logic       Reg_Write_D, Branch_D, Mdu_D;
  logic       Reg_Write_E, MemtoReg_E, Mdu_E;
  logic       Reg_Write_M, MemtoReg_M, Reg_Write_W;
  logic       Stall_F, Stall_D, Flush_E;
  logic [1:0] Forward_AE, Forward_BE;
  logic       Forward_AD, Forward_BD, Mdu_Done;
  logic [4:0] Mdu_Dst;
`ifdef HAZARD_PERF_EN
  logic [31:0] Lw_Stall_Cnt, Br_Stall_Cnt, Mdu_Stall_Cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard_unit #(
    .REG_AW  (5),
    .MDU_LAT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Rs_D        (Rs_D),
    .Rt_D        (Rt_D),
    .Write_Reg_D (Write_Reg_D),
    .Reg_Write_D (Reg_Write_D),
    .Branch_D    (Branch_D),
    .Mdu_D       (Mdu_D),
    .Rs_E        (Rs_E),
    .Rt_E        (Rt_E),
    .Write_Reg_E (Write_Reg_E),
    .Reg_Write_E (Reg_Write_E),
    .MemtoReg_E  (MemtoReg_E),
    .Mdu_E       (Mdu_E),
    .Write_Reg_M (Write_Reg_M),
    .Reg_Write_M (Reg_Write_M),
    .MemtoReg_M  (MemtoReg_M),
    .Write_Reg_W (Write_Reg_W),
    .Reg_Write_W (Reg_Write_W),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Flush_E     (Flush_E),
    .Forward_AE  (Forward_AE),
    .Forward_BE  (Forward_BE),
    .Forward_AD  (Forward_AD),
    .Forward_BD  (Forward_BD),
    .Mdu_Done    (Mdu_Done),
    .Mdu_Dst     (Mdu_Dst)
`ifdef HAZARD_PERF_EN
    ,
    .Lw_Stall_Cnt  (Lw_Stall_Cnt),
    .Br_Stall_Cnt  (Br_Stall_Cnt),
    .Mdu_Stall_Cnt (Mdu_Stall_Cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    Rs_D = '0; Rt_D = '0; Write_Reg_D = '0; Reg_Write_D = 1'b0; Branch_D = 1'b0; Mdu_D = 1'b0;
    Rs_E = '0; Rt_E = '0; Write_Reg_E = '0; Reg_Write_E = 1'b0; MemtoReg_E = 1'b0; Mdu_E = 1'b0;
    Write_Reg_M = '0; Reg_Write_M = 1'b0; MemtoReg_M = 1'b0;
    Write_Reg_W = '0; Reg_Write_W = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    int dones;
    rst_n = 1'b0;
    clr();
    Mdu_E = 1'b1; Write_Reg_E = 5'd8;
    tick(); tick();
    clr();
    #1;
    obs = {Stall_F, Stall_D, Flush_E, Forward_AE, Forward_BE, Forward_AD, Forward_BD, Mdu_Done, Mdu_Dst};
    n_tests++;
    if (obs !== 15'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0000", obs); end
    rst_n = 1'b1;
    dones = 0;
    Rs_D = 5'd8;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Mdu_Done || Stall_F) dones++;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL reset_no_issue: got %0d active cycles expected 0", dones); end
    clr();
  endtask

  task automatic test_lw_stall();
    clr();
    MemtoReg_E = 1'b1; Reg_Write_E = 1'b1; Write_Reg_E = 5'd2; Rs_D = 5'd2;
    #1;
    n_tests++;
    if ({Stall_F, Stall_D, Flush_E} !== 3'b111) begin n_fail++; $display("FAIL lw_stall: got %b expected 111", {Stall_F, Stall_D, Flush_E}); end
    tick(); clr();
    MemtoReg_M = 1'b1; Reg_Write_M = 1'b1; Write_Reg_M = 5'd2; Rs_D = 5'd2;
    #1;
    n_tests++;
    if ({Stall_F, Stall_D, Flush_E, Forward_AD} !== 4'b0001) begin n_fail++; $display("FAIL lw_bubble: got %b expected 0001", {Stall_F, Stall_D, Flush_E, Forward_AD}); end
    tick(); clr();
    Reg_Write_W = 1'b1; Write_Reg_W = 5'd2; Rs_E = 5'd2;
    #1;
    n_tests++;
    if ({Stall_F, Forward_AE} !== 3'b001) begin n_fail++; $display("FAIL lw_fwd_wb: got %b expected 001", {Stall_F, Forward_AE}); end
    clr();
    MemtoReg_E = 1'b1; Reg_Write_E = 1'b1; Write_Reg_E = 5'd0; Rs_D = 5'd0;
    #1;
    n_tests++;
    if (Stall_F !== 1'b0) begin n_fail++; $display("FAIL lw_reg0: got %b expected 0", Stall_F); end
    clr();
    MemtoReg_E = 1'b1; Reg_Write_E = 1'b1; Write_Reg_E = 5'd7; Rs_D = 5'd1; Rt_D = 5'd7;
    #1;
    n_tests++;
    if (Stall_D !== 1'b1) begin n_fail++; $display("FAIL lw_rt: got %b expected 1", Stall_D); end
    tick(); clr();
  endtask

  task automatic test_forward_e();
    clr();
    Reg_Write_M = 1'b1; Write_Reg_M = 5'd5; Reg_Write_W = 1'b1; Write_Reg_W = 5'd5;
    Rs_E = 5'd5; Rt_E = 5'd6;
    #1;
    n_tests++;
    if ({Forward_AE, Forward_BE} !== 4'b1000) begin n_fail++; $display("FAIL fwd_mem_prio: got %b expected 1000", {Forward_AE, Forward_BE}); end
    Reg_Write_M = 1'b0; Rt_E = 5'd5;
    #1;
    n_tests++;
    if ({Forward_AE, Forward_BE} !== 4'b0101) begin n_fail++; $display("FAIL fwd_wb: got %b expected 0101", {Forward_AE, Forward_BE}); end
    Reg_Write_M = 1'b1; Write_Reg_M = 5'd0; Write_Reg_W = 5'd0; Rs_E = 5'd0; Rt_E = 5'd0;
    #1;
    n_tests++;
    if ({Forward_AE, Forward_BE} !== 4'b0000) begin n_fail++; $display("FAIL fwd_reg0: got %b expected 0000", {Forward_AE, Forward_BE}); end
    clr();
  endtask

  task automatic test_branch();
    clr();
    Branch_D = 1'b1; Rs_D = 5'd3; Reg_Write_E = 1'b1; Write_Reg_E = 5'd3;
    #1;
    n_tests++;
    if ({Stall_F, Forward_AD} !== 2'b10) begin n_fail++; $display("FAIL br_stall_e: got %b expected 10", {Stall_F, Forward_AD}); end
    tick(); clr();
    Branch_D = 1'b1; Rs_D = 5'd3; Reg_Write_M = 1'b1; Write_Reg_M = 5'd3;
    #1;
    n_tests++;
    if ({Stall_F, Forward_AD, Forward_BD} !== 3'b010) begin n_fail++; $display("FAIL br_fwd_m: got %b expected 010", {Stall_F, Forward_AD, Forward_BD}); end
    clr();
    Branch_D = 1'b1; Rs_D = 5'd1; Rt_D = 5'd4; MemtoReg_M = 1'b1; Reg_Write_M = 1'b1; Write_Reg_M = 5'd4;
    #1;
    n_tests++;
    if ({Flush_E, Forward_BD} !== 2'b11) begin n_fail++; $display("FAIL br_stall_load_m: got %b expected 11", {Flush_E, Forward_BD}); end
    clr();
    Branch_D = 1'b1; Rs_D = 5'd0; Reg_Write_E = 1'b1; Write_Reg_E = 5'd0;
    #1;
    n_tests++;
    if (Stall_F !== 1'b0) begin n_fail++; $display("FAIL br_reg0: got %b expected 0", Stall_F); end
    tick(); clr();
  endtask

  task automatic test_mdu_raw();
    clr();
    Mdu_E = 1'b1; Reg_Write_E = 1'b1; Write_Reg_E = 5'd8; Rs_D = 5'd8;
    #1;
    n_tests++;
    if ({Stall_F, Mdu_Done} !== 2'b00) begin n_fail++; $display("FAIL mdu_pre_issue: got %b expected 00", {Stall_F, Mdu_Done}); end
    for (int c = 1; c <= 2; c++) begin
      tick(); clr(); Rs_D = 5'd8;
      #1;
      n_tests++;
      if ({Stall_F, Stall_D, Flush_E, Mdu_Done} !== 4'b1110) begin n_fail++; $display("FAIL mdu_raw_busy%0d: got %b expected 1110", c, {Stall_F, Stall_D, Flush_E, Mdu_Done}); end
    end
    tick(); clr(); Rs_D = 5'd8;
    #1;
    n_tests++;
    if ({Stall_F, Mdu_Done, Mdu_Dst} !== {1'b0, 1'b1, 5'd8}) begin n_fail++; $display("FAIL mdu_done: got %b expected 0101000", {Stall_F, Mdu_Done, Mdu_Dst}); end
    tick(); clr();
    #1;
    n_tests++;
    if ({Mdu_Done, Mdu_Dst} !== 6'd0) begin n_fail++; $display("FAIL mdu_after_done: got %b expected 000000", {Mdu_Done, Mdu_Dst}); end
  endtask

  task automatic test_back_to_back();
    clr();
    Mdu_E = 1'b1; Reg_Write_E = 1'b1; Write_Reg_E = 5'd9;
    for (int c = 1; c <= 2; c++) begin
      tick(); clr(); Mdu_D = 1'b1; Reg_Write_D = 1'b1; Write_Reg_D = 5'd10;
      #1;
      n_tests++;
      if (Stall_F !== 1'b1) begin n_fail++; $display("FAIL b2b_second_wait%0d: got %b expected 1", c, Stall_F); end
    end
    tick(); clr(); Mdu_E = 1'b1; Reg_Write_E = 1'b1; Write_Reg_E = 5'd10; Mdu_D = 1'b1;
    #1;
    n_tests++;
    if ({Stall_F, Mdu_Done, Mdu_Dst} !== {1'b0, 1'b1, 5'd9}) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 0101001", {Stall_F, Mdu_Done, Mdu_Dst}); end
    tick(); clr(); Reg_Write_D = 1'b1; Write_Reg_D = 5'd10;
    #1;
    n_tests++;
    if ({Stall_F, Mdu_Done} !== 2'b10) begin n_fail++; $display("FAIL b2b_waw: got %b expected 10", {Stall_F, Mdu_Done}); end
    tick(); clr(); Mdu_D = 1'b1;
    #1;
    n_tests++;
    if ({Stall_F, Mdu_Done} !== 2'b10) begin n_fail++; $display("FAIL b2b_struct: got %b expected 10", {Stall_F, Mdu_Done}); end
    tick(); clr(); Mdu_D = 1'b1;
    #1;
    n_tests++;
    if ({Stall_F, Mdu_Done, Mdu_Dst} !== {1'b0, 1'b1, 5'd10}) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 0101010", {Stall_F, Mdu_Done, Mdu_Dst}); end
    tick(); clr();
    #1;
    n_tests++;
    if (Mdu_Done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", Mdu_Done); end
  endtask

  task automatic test_mdu_zero_dst();
    int active;
    clr();
    Mdu_E = 1'b1; Write_Reg_E = 5'd0;
    active = 0;
    for (int c = 0; c < 5; c++) begin
      tick(); clr(); Mdu_D = 1'b1;
      #1;
      if (Mdu_Done || Stall_F) active++;
    end
    n_tests++;
    if (active !== 0) begin n_fail++; $display("FAIL mdu_zero_dst: got %0d active cycles expected 0", active); end
    clr();
  endtask

  task automatic test_reset_mid_op();
    int dones;
    clr();
    Mdu_E = 1'b1; Write_Reg_E = 5'd8;
    tick(); clr(); Rs_D = 5'd8;
    #1;
    n_tests++;
    if (Stall_F !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", Stall_F); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({Stall_F, Mdu_Done, Mdu_Dst} !== 7'd0) begin n_fail++; $display("FAIL rst_async_clear: got %b expected 0000000", {Stall_F, Mdu_Done, Mdu_Dst}); end
    tick(); tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (Mdu_Done || Stall_F) dones++;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL rst_aborted_op: got %0d active cycles expected 0", dones); end
    clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    test_reset();
    test_lw_stall();
    test_forward_e();
    test_branch();
    test_mdu_raw();
    test_back_to_back();
    test_mdu_zero_dst();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
